// File: rtl/axi_lite_slave.sv
// AXI4-Lite register slave: NUM_REGS word registers with byte strobes.
// Independent write/read FSMs; out-of-range accesses answer SLVERR.
module axi_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response channel
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data channel
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  // ---------------------------------------------------------------- write path
  w_state_t              w_state_reg, w_state_next;
  logic                  aw_ready, w_ready, aw_hs, w_hs, wr_commit;
  logic [ADDR_WIDTH-1:0] awaddr_reg, wr_addr;
  logic [DATA_WIDTH-1:0] wdata_reg, wr_data;
  logic [NB-1:0]         wstrb_reg, wr_strb;
  logic [1:0]            bresp_reg;
  logic                  wr_addr_ok;
  logic [IDX_W-1:0]      wr_idx;

  always_comb begin
    w_state_next = w_state_reg;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    case (w_state_reg)
      W_IDLE:      begin aw_ready = 1'b1; w_ready = 1'b1; end
      W_HAVE_ADDR: w_ready  = 1'b1;
      W_HAVE_DATA: aw_ready = 1'b1;
      W_RESP:      ;
    endcase
    // READYs must read 0 for as long as reset is held, not just after the edge
    if (rst) begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
    end
    aw_hs = AWVALID && aw_ready;
    w_hs  = WVALID && w_ready;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_next = W_RESP;
        else if (aw_hs)    w_state_next = W_HAVE_ADDR;
        else if (w_hs)     w_state_next = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)   w_state_next = W_RESP;
      W_HAVE_DATA: if (aw_hs)  w_state_next = W_RESP;
      W_RESP:      if (BREADY) w_state_next = W_IDLE;
    endcase
    wr_commit = (w_state_reg != W_RESP) && (w_state_next == W_RESP);
  end

  // The beat completing the pair is taken straight from the bus; the other from its holding register.
  assign wr_addr    = aw_hs ? AWADDR : awaddr_reg;
  assign wr_data    = w_hs ? WDATA : wdata_reg;
  assign wr_strb    = w_hs ? WSTRB : wstrb_reg;
  assign wr_addr_ok = (wr_addr < ADDR_LIMIT);
  assign wr_idx     = wr_addr[IDX_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_hs) awaddr_reg <= AWADDR;
      if (w_hs) begin
        wdata_reg <= WDATA;
        wstrb_reg <= WSTRB;
      end
      if (wr_commit) bresp_reg <= wr_addr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign AWREADY = aw_ready;
  assign WREADY  = w_ready;
  assign BVALID  = (w_state_reg == W_RESP) && !rst;
  assign BRESP   = BVALID ? bresp_reg : 2'b00;

  // ------------------------------------------------------------ register file
  logic [NUM_REGS-1:0][NB-1:0] byte_we;
  logic [DATA_WIDTH-1:0]       regs [NUM_REGS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      for (gj = 0; gj < NB; gj++) begin : g_lane
        assign byte_we[gi][gj] = wr_commit && wr_addr_ok && (wr_idx == IDX_W'(gi)) && wr_strb[gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        for (int j = 0; j < NB; j++)
          if (byte_we[i][j]) regs[i][8*j +: 8] <= wr_data[8*j +: 8];
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t              r_state_reg, r_state_next;
  logic                  ar_ready, ar_hs, rd_addr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  always_comb begin
    r_state_next = r_state_reg;
    ar_ready     = (r_state_reg == R_IDLE) && !rst;
    ar_hs        = ARVALID && ar_ready;
    case (r_state_reg)
      R_IDLE: if (ar_hs)  r_state_next = R_RESP;
      R_RESP: if (RREADY) r_state_next = R_IDLE;
    endcase
  end

  assign rd_addr_ok = (ARADDR < ADDR_LIMIT);
  assign rd_idx     = ARADDR[IDX_W+1:2];

  // Non-blocking sampling of regs yields the pre-write value on a colliding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_hs) begin
        rdata_reg <= rd_addr_ok ? regs[rd_idx] : '0;
        rresp_reg <= rd_addr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign ARREADY = ar_ready;
  assign RVALID  = (r_state_reg == R_RESP) && !rst;
  assign RDATA   = RVALID ? rdata_reg : '0;
  assign RRESP   = RVALID ? rresp_reg : 2'b00;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Self-checking bench for axi_lite_slave: reference register model feeds
// expectation queues that are popped when the DUT responds.
module tb_axi_lite_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  always #5 clk = ~clk;

  axi_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [8];
  exp_t        wr_q [$];
  exp_t        rd_q [$];

  // ------------------------------------------------------------ reference model
  function automatic void exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.data = 32'h0;
    if (a < 32'd32) begin
      e.resp = 2'b00;
      for (int j = 0; j < 4; j++)
        if (s[j]) model[a[4:2]][8*j +: 8] = d[8*j +: 8];
    end else begin
      e.resp = 2'b10;
    end
    wr_q.push_back(e);
  endfunction

  function automatic void exp_read(input logic [31:0] a);
    exp_t e;
    if (a < 32'd32) begin
      e.resp = 2'b00;
      e.data = model[a[4:2]];
    end else begin
      e.resp = 2'b10;
      e.data = 32'h0;
    end
    rd_q.push_back(e);
  endfunction

  // ------------------------------------------------------------ bus drivers
  // All driving and sampling happens on the falling edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output bit lat_ok, output bit hold_ok,
                           output bit to);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    logic [1:0] first_resp;
    aw_done = 0; w_done = 0; hold_ok = 1; to = 0; lat_ok = 0; resp = 2'bxx;
    @(negedge clk);
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 200) begin
      if (!aw_done && cyc >= aw_dly) begin AWADDR = a; AWVALID = 1'b1; end
      if (!w_done && cyc >= w_dly) begin WDATA = d; WSTRB = s; WVALID = 1'b1; end
      // a channel already consumed must not be offered again while waiting
      if ((aw_done && AWREADY !== 1'b0) || (w_done && WREADY !== 1'b0)) hold_ok = 0;
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(negedge clk);
      cyc++;
      if (aw_fire) begin aw_done = 1; AWVALID = 1'b0; end
      if (w_fire)  begin w_done = 1;  WVALID  = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      AWVALID = 1'b0; WVALID = 1'b0; to = 1;
      return;
    end
    lat_ok = (BVALID === 1'b1);
    first_resp = BRESP;
    for (int i = 0; i < b_dly; i++) begin
      if (BVALID !== 1'b1 || BRESP !== first_resp || AWREADY !== 1'b0 || WREADY !== 1'b0) hold_ok = 0;
      @(negedge clk);
    end
    cyc = 0;
    while (BVALID !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (BVALID !== 1'b1) begin to = 1; return; end
    resp = BRESP;
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    if (BVALID !== 1'b0 || BRESP !== 2'b00) hold_ok = 0;
    $display("write addr=%h data=%h strb=%h resp=%b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output bit lat_ok, output bit hold_ok, output bit to);
    bit fired;
    int cyc;
    hold_ok = 1; to = 0; lat_ok = 0; data = 'x; resp = 'x;
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1; fired = 0; cyc = 0;
    while (!fired && cyc < 200) begin
      fired = ARREADY;
      @(negedge clk);
      cyc++;
    end
    ARVALID = 1'b0;
    if (!fired) begin to = 1; return; end
    lat_ok = (RVALID === 1'b1);
    cyc = 0;
    while (RVALID !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    if (RVALID !== 1'b1) begin to = 1; return; end
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < r_dly; i++) begin
      if (RVALID !== 1'b1 || RDATA !== data || RRESP !== resp || ARREADY !== 1'b0) hold_ok = 0;
      @(negedge clk);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    if (RVALID !== 1'b0 || RDATA !== 32'h0 || RRESP !== 2'b00) hold_ok = 0;
    $display("read  addr=%h data=%h resp=%b", a, data, resp);
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got aw/w/ar_ready,bvalid,rvalid=%b required 00000",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < 8; i++) begin
      exp_read(32'(i * 4));
      axi_read(32'(i * 4), 0, d, r, lat, hold, to);
      e = rd_q.pop_front();
      checks++;
      if (to || d !== e.data || r !== e.resp) begin
        errors++;
        $display("FAIL reset_reg%0d: got data=%h resp=%b required data=%h resp=%b", i, d, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    exp_write(32'h04, 32'hDEADBEEF, 4'hF);
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat, hold, to);
    e = wr_q.pop_front();
    checks++;
    if (to || r !== e.resp || !lat) begin
      errors++;
      $display("FAIL basic_write: got bresp=%b bvalid_next=%0d timeout=%0d required bresp=%b bvalid_next=1", r, lat, to, e.resp);
    end
    exp_read(32'h04);
    axi_read(32'h04, 0, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++;
      $display("FAIL basic_read: got data=%h resp=%b required data=%h resp=%b", d, r, e.data, e.resp);
    end
    checks++;
    if (!lat || !hold) begin
      errors++;
      $display("FAIL basic_read_timing: got rvalid_next=%0d idle_zero=%0d required 1 1", lat, hold);
    end
  endtask

  task automatic test_w_first();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    exp_write(32'h08, 32'h11223344, 4'hF);
    axi_write(32'h08, 32'h11223344, 4'hF, 3, 0, 0, r, lat, hold, to);
    e = wr_q.pop_front();
    checks++;
    if (to || r !== e.resp || !lat || !hold) begin
      errors++;
      $display("FAIL w_first_write: got bresp=%b bvalid_next=%0d wready_low=%0d required bresp=%b 1 1", r, lat, hold, e.resp);
    end
    exp_read(32'h08);
    axi_read(32'h08, 0, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++;
      $display("FAIL w_first_read: got data=%h resp=%b required data=%h resp=%b", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_aw_first();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    exp_write(32'h1C, 32'hCAFEF00D, 4'hF);
    axi_write(32'h1C, 32'hCAFEF00D, 4'hF, 0, 2, 0, r, lat, hold, to);
    e = wr_q.pop_front();
    checks++;
    if (to || r !== e.resp || !lat || !hold) begin
      errors++;
      $display("FAIL aw_first_write: got bresp=%b bvalid_next=%0d awready_low=%0d required bresp=%b 1 1", r, lat, hold, e.resp);
    end
    exp_read(32'h1C);
    axi_read(32'h1C, 0, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++;
      $display("FAIL aw_first_read: got data=%h resp=%b required data=%h resp=%b", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    logic [31:0] wa [4] = '{32'h00, 32'h00, 32'h0D, 32'h0C};
    logic [31:0] wd [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'hAAAAAAAA};
    logic [3:0]  ws [4] = '{4'hF, 4'b0101, 4'hF, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      exp_write(wa[i], wd[i], ws[i]);
      axi_write(wa[i], wd[i], ws[i], 0, 0, 0, r, lat, hold, to);
      e = wr_q.pop_front();
      checks++;
      if (to || r !== e.resp) begin
        errors++;
        $display("FAIL strobe_bresp%0d: got %b required %b", i, r, e.resp);
      end
    end
    exp_read(32'h00);
    axi_read(32'h00, 0, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || e.data !== 32'hFF00FF00) begin
      errors++;
      $display("FAIL strobe_reg0: got %h required %h", d, e.data);
    end
    exp_read(32'h0E);
    axi_read(32'h0E, 0, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++;
      $display("FAIL strobe_zero_reg3: got data=%h resp=%b required data=%h resp=%b", d, r, e.data, e.resp);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    logic [31:0] bad [2] = '{32'h40, 32'h20};
    for (int k = 0; k < 2; k++) begin
      exp_write(bad[k], 32'h5A5A5A5A, 4'hF);
      axi_write(bad[k], 32'h5A5A5A5A, 4'hF, 0, 0, 0, r, lat, hold, to);
      e = wr_q.pop_front();
      checks++;
      if (to || r !== e.resp) begin
        errors++;
        $display("FAIL invalid_bresp_%h: got %b required %b", bad[k], r, e.resp);
      end
      exp_read(bad[k]);
      axi_read(bad[k], 0, d, r, lat, hold, to);
      e = rd_q.pop_front();
      checks++;
      if (to || d !== e.data || r !== e.resp) begin
        errors++;
        $display("FAIL invalid_read_%h: got data=%h resp=%b required data=%h resp=%b", bad[k], d, r, e.data, e.resp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_read(32'(i * 4));
      axi_read(32'(i * 4), 0, d, r, lat, hold, to);
      e = rd_q.pop_front();
      checks++;
      if (to || d !== e.data || r !== e.resp) begin
        errors++;
        $display("FAIL invalid_untouched_reg%0d: got %h required %h", i, d, e.data);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    exp_write(32'h10, 32'h0BADF00D, 4'hF);
    axi_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 5, r, lat, hold, to);
    e = wr_q.pop_front();
    checks++;
    if (to || r !== e.resp || !hold) begin
      errors++;
      $display("FAIL stall_write: got bresp=%b held_stable=%0d required bresp=%b held_stable=1", r, hold, e.resp);
    end
    exp_read(32'h10);
    axi_read(32'h10, 5, d, r, lat, hold, to);
    e = rd_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp || !hold) begin
      errors++;
      $display("FAIL stall_read: got data=%h held_stable=%0d required data=%h held_stable=1", d, hold, e.data);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd_d; logic [1:0] wr_r, rd_r; bit wl, wh, wt, rl, rh, rt; exp_t e;
    exp_read(32'h04);
    exp_write(32'h04, 32'h76543210, 4'hF);
    fork
      axi_write(32'h04, 32'h76543210, 4'hF, 0, 0, 0, wr_r, wl, wh, wt);
      axi_read(32'h04, 0, rd_d, rd_r, rl, rh, rt);
    join
    e = rd_q.pop_front();
    checks++;
    if (rt || rd_d !== e.data) begin
      errors++;
      $display("FAIL simultaneous_old_value: got %h required %h", rd_d, e.data);
    end
    e = wr_q.pop_front();
    checks++;
    if (wt || wr_r !== e.resp) begin
      errors++;
      $display("FAIL simultaneous_bresp: got %b required %b", wr_r, e.resp);
    end
    exp_read(32'h04);
    axi_read(32'h04, 0, rd_d, rd_r, rl, rh, rt);
    e = rd_q.pop_front();
    checks++;
    if (rt || rd_d !== e.data) begin
      errors++;
      $display("FAIL simultaneous_new_value: got %h required %h", rd_d, e.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, wd, d; logic [3:0] s; logic [1:0] r; bit lat, hold, to; exp_t e;
    for (int n = 0; n < 24; n++) begin
      a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom();
        s  = 4'($urandom_range(0, 15));
        exp_write(a, wd, s);
        axi_write(a, wd, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), r, lat, hold, to);
        e = wr_q.pop_front();
        checks++;
        if (to || r !== e.resp || !lat || !hold) begin
          errors++;
          $display("FAIL b2b_write%0d: got bresp=%b lat=%0d hold=%0d required bresp=%b 1 1", n, r, lat, hold, e.resp);
        end
      end else begin
        exp_read(a);
        axi_read(a, $urandom_range(0, 2), d, r, lat, hold, to);
        e = rd_q.pop_front();
        checks++;
        if (to || d !== e.data || r !== e.resp || !lat || !hold) begin
          errors++;
          $display("FAIL b2b_read%0d: got data=%h resp=%b lat=%0d hold=%0d required data=%h resp=%b 1 1",
                   n, d, r, lat, hold, e.data, e.resp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit lat, hold, to; exp_t e;
    @(negedge clk);
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'h99999999; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h14; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pending: got bvalid=%b rvalid=%b required 1 1", BVALID, RVALID);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({BVALID, RVALID, BRESP, RRESP, AWREADY, WREADY, ARREADY} !== 9'b0 || RDATA !== 32'h0) begin
      errors++;
      $display("FAIL midrst_abort: got bv=%b rv=%b bresp=%b rresp=%b readys=%b rdata=%h required all 0",
               BVALID, RVALID, BRESP, RRESP, {AWREADY, WREADY, ARREADY}, RDATA);
    end
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_release_ready: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < 8; i++) begin
      exp_read(32'(i * 4));
      axi_read(32'(i * 4), 0, d, r, lat, hold, to);
      e = rd_q.pop_front();
      checks++;
      if (to || d !== e.data) begin
        errors++;
        $display("FAIL midrst_reg%0d: got %h required %h", i, d, e.data);
      end
    end
  endtask

  initial begin
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    test_reset();
    test_basic();
    test_w_first();
    test_aw_first();
    test_strobe();
    test_invalid();
    test_stall();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
